riscv_zero_mem_arbiter: RTL and testbench

Shares the single-port instruction/data ram between two requesters: the fetch stage (read-only, 32-bit instructions) and the load/store unit (64-bit reads and writes). Arbitration is pipelined, accepts at most one transaction per cycle, and returns read responses in order. Data requests have priority, with a bounded-starvation guarantee for fetch. A flush input drops in-flight fetch responses when a branch redirects the pc.

---
 rtl/riscv_zero_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_riscv_zero_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_zero_mem_arbiter.sv
// ----------------------------------------------------------------------------
// riscv_zero_mem_arbiter
//
// Shares one single-port RAM between the fetch stage (32-bit reads) and the
// load/store unit (64-bit reads and writes). The pipeline has three stages:
//   T   : combinational grant, at most one transaction per cycle
//   T+1 : issue, the registered mem_* outputs drive the RAM
//   T+2 : response, the RAM read data is returned with a one-cycle rvalid
// Responses therefore return in issue order with a fixed two-cycle latency.
//
// Handshake: a requester raises req with a stable address (and, for data,
// we/wdata). It holds them until it sees gnt high in the same cycle. The
// transaction is accepted on that clock edge. Read data is returned two
// cycles after gnt, qualified by a single-cycle rvalid. Writes return nothing.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   if_req/if_addr           fetch read request
//   if_flush                 drop fetch responses granted before this cycle
//   if_gnt/if_rvalid/if_rdata fetch grant and response
//   d_req/d_we/d_addr/d_wdata data request (read or write)
//   d_gnt/d_rvalid/d_rdata   data grant and response
//   mem_write_enable/mem_address/mem_data_in  RAM issue-stage outputs
//   mem_data_out             RAM read data, valid one cycle after the address
//
// Parameters:
//   MAX_DATA_RUN  contended data grants allowed before fetch is forced (1..15)
//   ADDR_W        address width on all ports
// ----------------------------------------------------------------------------
module riscv_zero_mem_arbiter #(
  parameter int MAX_DATA_RUN = 4,
  parameter int ADDR_W       = 64
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,

  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_data_in,
  input  logic [63:0]       mem_data_out
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);

  // High during the first cycle after reset is released. Grants are held off
  // for that cycle so the pipeline restarts from a clean issue stage.
  logic       reset_q;
  // Consecutive contended cycles that data has won.
  logic [3:0] run_cnt;
  // In-flight read markers: issue stage and response stage.
  logic       iss_if;
  logic       iss_d;
  logic       rsp_if;
  logic       rsp_d;

  logic       grant_ok;
  logic       force_fetch;

  // --------------------------------------------------------------------------
  // Grant: data wins unless fetch is waiting and data has used its run.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_ok    = ~reset & ~reset_q;
    force_fetch = (run_cnt == RUN_MAX);
    d_gnt       = grant_ok & d_req & ~(if_req & force_fetch);
    if_gnt      = grant_ok & if_req & ~d_gnt;
  end

  // --------------------------------------------------------------------------
  // Issue and response stages.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      reset_q          <= 1'b1;
      run_cnt          <= 4'd0;
      iss_if           <= 1'b0;
      iss_d            <= 1'b0;
      rsp_if           <= 1'b0;
      rsp_d            <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data_in      <= '0;
    end else begin
      reset_q <= 1'b0;

      // Starvation bound: count only data grants that made fetch wait.
      if (if_gnt || !if_req) begin
        run_cnt <= 4'd0;
      end else if (d_gnt && run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + 4'd1;
      end

      // A fetch granted in the flush cycle belongs to the new pc and is kept;
      // only the fetch already in the issue stage is dropped.
      iss_if <= if_gnt;
      iss_d  <= d_gnt & ~d_we;
      rsp_if <= iss_if & ~if_flush;
      rsp_d  <= iss_d;

      mem_write_enable <= d_gnt & d_we;
      if (d_gnt) begin
        mem_address <= d_addr;
        // Write data is held between writes rather than cleared.
        if (d_we) begin
          mem_data_in <= d_wdata;
        end
      end else if (if_gnt) begin
        mem_address <= if_addr;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Responses: RAM data is presented directly. A flush in the response cycle
  // also kills that cycle's fetch response, and reset silences both.
  // --------------------------------------------------------------------------
  always_comb begin
    if_rvalid = rsp_if & ~if_flush & ~reset;
    d_rvalid  = rsp_d & ~reset;
    if_rdata  = mem_data_out[31:0];
    d_rdata   = mem_data_out;
  end

endmodule

// File: tb/tb_riscv_zero_mem_arbiter.sv
module tb_riscv_zero_mem_arbiter;

  localparam int ADDR_W = 64;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_flush = 1'b0;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req = 1'b0;
  logic              d_we = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [63:0]       d_wdata = '0;
  logic              d_gnt;
  logic              d_rvalid;
  logic [63:0]       d_rdata;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_data_in;
  logic [63:0]       mem_data_out;

  riscv_zero_mem_arbiter #(.MAX_DATA_RUN(4), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  // --------------------------------------------------------------------------
  // RAM model (synchronous read, write lands on the issue-cycle edge)
  // --------------------------------------------------------------------------
  logic [63:0] ram [0:255];
  logic [63:0] ref_mem [0:255];

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0;
      ref_mem[i] = '0;
    end
  end

  always @(posedge clk) begin
    mem_data_out <= ram[mem_address[7:0]];
    if (mem_write_enable) ram[mem_address[7:0]] = mem_data_in;
  end

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  exp_t exp_if_q[$];
  exp_t exp_d_q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cycle, obs, exp);
    end
  endtask

  // Response monitor: every cycle, rvalid must match whether a response is due.
  always @(negedge clk) begin
    logic exp_now;
    exp_t e;
    while (exp_if_q.size() > 0 && exp_if_q[0].due < cycle) void'(exp_if_q.pop_front());
    while (exp_d_q.size() > 0 && exp_d_q[0].due < cycle) void'(exp_d_q.pop_front());

    exp_now = (exp_if_q.size() > 0 && exp_if_q[0].due == cycle);
    chk("if_rvalid", {63'b0, if_rvalid}, {63'b0, exp_now});
    if (exp_now) begin
      e = exp_if_q.pop_front();
      chk("if_rdata", {32'b0, if_rdata}, {32'b0, e.data[31:0]});
    end

    exp_now = (exp_d_q.size() > 0 && exp_d_q[0].due == cycle);
    chk("d_rvalid", {63'b0, d_rvalid}, {63'b0, exp_now});
    if (exp_now) begin
      e = exp_d_q.pop_front();
      chk("d_rdata", d_rdata, e.data);
    end
  end

  // --------------------------------------------------------------------------
  // Driver: one step = one clock cycle of stimulus plus its expected grants
  // --------------------------------------------------------------------------
  logic        iss_known = 1'b0;
  logic        zero_exp = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_we = 1'b0;
  logic [63:0] prev_addr = '0;
  logic [63:0] prev_wdata = '0;
  logic [63:0] last_wdata = '0;

  task automatic step(input logic rst,
                      input logic ireq, input logic [63:0] iaddr, input logic flush,
                      input logic dreq, input logic dwe, input logic [63:0] daddr,
                      input logic [63:0] dwd,
                      input logic eig, input logic edg);
    logic exp_we;
    @(posedge clk);
    #1;
    reset = rst; if_req = ireq; if_addr = iaddr; if_flush = flush;
    d_req = dreq; d_we = dwe; d_addr = daddr; d_wdata = dwd;
    if (rst) begin
      exp_if_q.delete();
      exp_d_q.delete();
    end else if (flush) begin
      exp_if_q.delete();
    end
    @(negedge clk);

    // Issue stage reflects the previous cycle's grant.
    if (iss_known) begin
      exp_we = prev_valid & prev_we;
      chk("mem_write_enable", {63'b0, mem_write_enable}, {63'b0, exp_we});
      chk("mem_data_in", mem_data_in, exp_we ? prev_wdata : last_wdata);
      if (exp_we) last_wdata = prev_wdata;
      if (prev_valid) chk("mem_address", mem_address, prev_addr);
      else if (zero_exp) chk("mem_address_reset", mem_address, 64'h0);
    end

    chk("if_gnt", {63'b0, if_gnt}, {63'b0, eig});
    chk("d_gnt", {63'b0, d_gnt}, {63'b0, edg});

    prev_valid = 1'b0;
    if (edg) begin
      prev_valid = 1'b1; prev_we = dwe; prev_addr = daddr; prev_wdata = dwd;
      if (dwe) ref_mem[daddr[7:0]] = dwd;
      else exp_d_q.push_back('{due: cycle + 2, data: ref_mem[daddr[7:0]]});
    end else if (eig) begin
      prev_valid = 1'b1; prev_we = 1'b0; prev_addr = iaddr;
      exp_if_q.push_back('{due: cycle + 2, data: ref_mem[iaddr[7:0]]});
    end

    zero_exp = rst;
    if (rst) begin
      prev_valid = 1'b0;
      last_wdata = '0;
      iss_known = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    // Reset with requests present: no grants during reset or the cycle after.
    step(1, 1, 64'h0, 0, 1, 0, 64'h0, 64'h0, 0, 0);
    step(1, 1, 64'h0, 0, 1, 0, 64'h0, 64'h0, 0, 0);
    step(0, 1, 64'h0, 0, 1, 0, 64'h0, 64'h0, 0, 0);
    idle(1);

    // Preload: three back-to-back writes, then fetch 0x1C.
    step(0, 0, 64'h0, 0, 1, 1, 64'h0,  64'hABCD1234, 0, 1);
    step(0, 0, 64'h0, 0, 1, 1, 64'h4,  64'hABCD5678, 0, 1);
    step(0, 0, 64'h0, 0, 1, 1, 64'h1C, 64'hCAB1DAB1, 0, 1);
    step(0, 1, 64'h1C, 0, 0, 0, 64'h0, 64'h0, 1, 0);
    idle(3);

    // Streaming fetch.
    step(0, 1, 64'h0, 0, 0, 0, 64'h0, 64'h0, 1, 0);
    step(0, 1, 64'h4, 0, 0, 0, 64'h0, 64'h0, 1, 0);
    step(0, 1, 64'h8, 0, 0, 0, 64'h0, 64'h0, 1, 0);
    idle(3);

    // Contention: D,D,D,D,F repeating.
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 64'h1C, 0, 1, 0, 64'h4, 64'h0, (i % 5) == 4, (i % 5) != 4);
    end
    idle(3);

    // Flush: only the fetch granted in the flush cycle survives.
    step(0, 1, 64'h0,  0, 0, 0, 64'h0, 64'h0, 1, 0);
    step(0, 1, 64'h4,  0, 0, 0, 64'h0, 64'h0, 1, 0);
    step(0, 1, 64'h1C, 1, 0, 0, 64'h0, 64'h0, 1, 0);
    idle(4);

    // Write then read of the same address on consecutive grants.
    step(0, 0, 64'h0, 0, 1, 1, 64'h8, 64'h08080808, 0, 1);
    step(0, 0, 64'h0, 0, 1, 0, 64'h8, 64'h0, 0, 1);
    idle(3);

    // Data write with fetch waiting, then fetch.
    step(0, 1, 64'h0, 0, 1, 1, 64'h10, 64'h1122334455667788, 0, 1);
    step(0, 1, 64'h10, 0, 0, 0, 64'h0, 64'h0, 1, 0);
    idle(3);

    // Reset mid-operation: the in-flight read is never delivered.
    step(0, 0, 64'h0, 0, 1, 0, 64'h8, 64'h0, 0, 1);
    step(1, 0, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0);
    step(0, 1, 64'h0, 0, 0, 0, 64'h0, 64'h0, 0, 0);
    step(0, 1, 64'h0, 0, 0, 0, 64'h0, 64'h0, 1, 0);
    idle(4);

    chk("pending_if_responses", 64'(exp_if_q.size()), 64'h0);
    chk("pending_d_responses", 64'(exp_d_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
